// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects, load-use / memory-wait stalls and stall counters
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              m_valid,
  input  logic              m_wen,
  input  logic              m_is_load,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_ready,
  input  logic              wb_valid,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush,
  output logic [2:0]        rs1_fwd_sel,
  output logic [2:0]        rs2_fwd_sel,
  output logic              stall_fe,
  output logic              bubble_ex,
  output logic              stall_all,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  lu_events
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_stall_cycles, r_lu_events;
  logic w_s1, w_s2, w_ex_p, w_m_p, w_wb_p;
  logic w_ex1, w_ex2, w_m1, w_m2, w_wb1, w_wb2;
  logic w_mw, w_lu, w_so, w_haz, w_lu_enter;
  logic [2:0] w_sel1, w_sel2;
  assign w_s1   = id_valid & id_rs1_used;
  assign w_s2   = id_valid & id_rs2_used;
  assign w_ex_p = ex_valid & ex_wen & (ex_rd != '0);
  assign w_m_p  = m_valid & m_wen & (m_rd != '0);
  assign w_wb_p = wb_valid & wb_wen & (wb_rd != '0);
  assign w_ex1  = w_s1 & w_ex_p & (ex_rd == id_rs1);
  assign w_ex2  = w_s2 & w_ex_p & (ex_rd == id_rs2);
  assign w_m1   = w_s1 & w_m_p & (m_rd == id_rs1);
  assign w_m2   = w_s2 & w_m_p & (m_rd == id_rs2);
  assign w_wb1  = w_s1 & w_wb_p & (wb_rd == id_rs1);
  assign w_wb2  = w_s2 & w_wb_p & (wb_rd == id_rs2);
  assign w_sel1 = w_ex1 ? 3'd1 : w_m1 ? (m_is_load ? 3'd3 : 3'd2) : w_wb1 ? 3'd4 : 3'd0;
  assign w_sel2 = w_ex2 ? 3'd1 : w_m2 ? (m_is_load ? 3'd3 : 3'd2) : w_wb2 ? 3'd4 : 3'd0;
  assign rs1_fwd_sel = FWD_EN ? w_sel1 : 3'd0;
  assign rs2_fwd_sel = FWD_EN ? w_sel2 : 3'd0;
  assign w_mw   = m_valid & m_is_load & ~m_ready;
  assign w_lu   = FWD_EN & ex_is_load & (w_ex1 | w_ex2);
  assign w_so   = ~FWD_EN & (w_ex1 | w_ex2 | w_m1 | w_m2 | w_wb1 | w_wb2);
  assign w_haz  = ~flush & (w_lu | w_so);
  assign stall_all = w_mw;
  assign stall_fe  = w_mw | w_haz;
  assign bubble_ex = ~w_mw & w_haz;
  assign w_lu_enter = ~w_mw & ~flush & w_lu & (r_state == RUN);
  assign stall_cycles = r_stall_cycles;
  assign lu_events    = r_lu_events;
  // state transitions and saturating stall / load-use counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_stall_cycles <= '0;
      r_lu_events    <= '0;
    end else begin
      r_state <= w_mw ? MEM_WAIT : w_lu_enter ? LU_STALL : RUN;
      if (stall_fe && !(&r_stall_cycles)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_lu_enter && !(&r_lu_events)) r_lu_events <= r_lu_events + 1'b1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: vector table plus multi-cycle sequences for fwd_hazard_unit
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1, id_rs2, ex_rd, m_rd, wb_rd;
  logic ex_valid, ex_wen, ex_is_load, m_valid, m_wen, m_is_load, m_ready;
  logic wb_valid, wb_wen, flush;
  logic [2:0] s1_a, s2_a, s1_b, s2_b;
  logic fe_a, bub_a, all_a, fe_b, bub_b, all_b;
  logic [3:0] sc_a, lu_a, sc_b, lu_b;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic idv, u1, u2;
    logic [4:0] rs1, rs2;
    logic [2:0] ex;
    logic [4:0] exrd;
    logic [2:0] m;
    logic [4:0] mrd;
    logic mr;
    logic [1:0] wb;
    logic [4:0] wbrd;
    logic fl;
    logic [2:0] s1, s2;
    logic fe, bub, all, fe0;
  } vec_t;
  vec_t tbl[18];
  vec_t sbq[$];
  vec_t e;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .m_valid(m_valid), .m_wen(m_wen), .m_is_load(m_is_load), .m_rd(m_rd),
    .m_ready(m_ready), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .flush(flush), .rs1_fwd_sel(s1_a), .rs2_fwd_sel(s2_a), .stall_fe(fe_a),
    .bubble_ex(bub_a), .stall_all(all_a), .stall_cycles(sc_a), .lu_events(lu_a));

  fwd_hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .m_valid(m_valid), .m_wen(m_wen), .m_is_load(m_is_load), .m_rd(m_rd),
    .m_ready(m_ready), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd),
    .flush(flush), .rs1_fwd_sel(s1_b), .rs2_fwd_sel(s2_b), .stall_fe(fe_b),
    .bubble_ex(bub_b), .stall_all(all_b), .stall_cycles(sc_b), .lu_events(lu_b));

  function automatic vec_t mk(logic idv, logic u1, logic u2, logic [4:0] rs1, logic [4:0] rs2,
                              logic [2:0] ex, logic [4:0] exrd, logic [2:0] m, logic [4:0] mrd,
                              logic mr, logic [1:0] wb, logic [4:0] wbrd, logic fl,
                              logic [2:0] s1, logic [2:0] s2, logic fe, logic bub, logic all,
                              logic fe0);
    vec_t v;
    v.idv = idv; v.u1 = u1; v.u2 = u2; v.rs1 = rs1; v.rs2 = rs2;
    v.ex = ex; v.exrd = exrd; v.m = m; v.mrd = mrd; v.mr = mr;
    v.wb = wb; v.wbrd = wbrd; v.fl = fl;
    v.s1 = s1; v.s2 = s2; v.fe = fe; v.bub = bub; v.all = all; v.fe0 = fe0;
    return v;
  endfunction

  task automatic set(vec_t v);
    id_valid = v.idv; id_rs1_used = v.u1; id_rs2_used = v.u2;
    id_rs1 = v.rs1; id_rs2 = v.rs2;
    {ex_valid, ex_wen, ex_is_load} = v.ex; ex_rd = v.exrd;
    {m_valid, m_wen, m_is_load} = v.m; m_rd = v.mrd; m_ready = v.mr;
    {wb_valid, wb_wen} = v.wb; wb_rd = v.wbrd; flush = v.fl;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set(mk(0,0,0,0,0, 3'b000,0, 3'b000,0,1, 2'b00,0, 0, 0,0,0,0,0,0));
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t lu_v, mw_v;

  initial begin
    tbl[0]  = mk(1,1,1,5,5,   3'b110,5,  3'b000,0,1,  2'b00,0, 0, 1,1,0,0,0,1);
    tbl[1]  = mk(1,1,0,3,3,   3'b110,3,  3'b110,3,1,  2'b11,3, 0, 1,0,0,0,0,1);
    tbl[2]  = mk(1,1,1,0,0,   3'b110,0,  3'b110,0,1,  2'b11,0, 0, 0,0,0,0,0,0);
    tbl[3]  = mk(1,1,1,0,4,   3'b000,0,  3'b110,4,1,  2'b00,0, 0, 0,2,0,0,0,1);
    tbl[4]  = mk(1,1,1,4,0,   3'b000,0,  3'b111,4,1,  2'b00,0, 0, 3,0,0,0,0,1);
    tbl[5]  = mk(1,1,1,9,9,   3'b000,0,  3'b000,0,1,  2'b11,9, 0, 4,4,0,0,0,1);
    tbl[6]  = mk(1,1,1,9,9,   3'b000,0,  3'b000,0,1,  2'b11,9, 1, 4,4,0,0,0,0);
    tbl[7]  = mk(1,0,1,6,0,   3'b110,6,  3'b000,0,1,  2'b00,0, 0, 0,0,0,0,0,0);
    tbl[8]  = mk(0,1,1,6,6,   3'b110,6,  3'b000,0,1,  2'b00,0, 0, 0,0,0,0,0,0);
    tbl[9]  = mk(1,1,0,8,0,   3'b000,0,  3'b110,8,1,  2'b11,8, 0, 2,0,0,0,0,1);
    tbl[10] = mk(1,1,0,8,0,   3'b100,8,  3'b000,0,1,  2'b11,8, 0, 4,0,0,0,0,1);
    tbl[11] = mk(1,0,1,0,8,   3'b010,8,  3'b000,0,1,  2'b00,0, 0, 0,0,0,0,0,0);
    tbl[12] = mk(1,0,1,0,7,   3'b111,7,  3'b000,0,1,  2'b00,0, 0, 0,1,1,1,0,1);
    tbl[13] = mk(1,0,1,0,7,   3'b111,7,  3'b000,0,1,  2'b00,0, 1, 0,1,0,0,0,0);
    tbl[14] = mk(1,0,0,0,0,   3'b000,0,  3'b111,10,0, 2'b00,0, 0, 0,0,1,0,1,1);
    tbl[15] = mk(1,1,1,10,10, 3'b000,0,  3'b111,10,0, 2'b00,0, 1, 3,3,1,0,1,1);
    tbl[16] = mk(1,1,0,7,0,   3'b111,7,  3'b111,10,0, 2'b00,0, 0, 1,0,1,0,1,1);
    tbl[17] = mk(1,1,0,2,0,   3'b111,7,  3'b000,0,1,  2'b00,0, 0, 0,0,0,0,0,0);
    lu_v = mk(1,0,1,0,7, 3'b111,7, 3'b000,0,1, 2'b00,0, 0, 0,0,0,0,0,0);
    mw_v = mk(0,0,0,0,0, 3'b000,0, 3'b111,10,0, 2'b00,0, 0, 0,0,0,0,0,0);

    do_reset();
    @(negedge clk);
    chk("rst_sc", sc_a, 0);
    chk("rst_lu", lu_a, 0);
    chk("rst_fe", fe_a, 0);
    chk("rst_all", all_a, 0);

    for (int i = 0; i < 18; i++) begin
      tick();
      set(tbl[i]);
      sbq.push_back(tbl[i]);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("v%0d_s1", i), s1_a, e.s1);
      chk($sformatf("v%0d_s2", i), s2_a, e.s2);
      chk($sformatf("v%0d_fe", i), fe_a, e.fe);
      chk($sformatf("v%0d_bub", i), bub_a, e.bub);
      chk($sformatf("v%0d_all", i), all_a, e.all);
      chk($sformatf("v%0d_sel0", i), {s1_b, s2_b}, 0);
      chk($sformatf("v%0d_fe0", i), fe_b, e.fe0);
      chk($sformatf("v%0d_bub0", i), bub_b, e.fe0 & ~e.all);
      chk($sformatf("v%0d_all0", i), all_b, e.all);
    end

    do_reset();
    set(lu_v);
    @(negedge clk);
    chk("lu_c1_fe", fe_a, 1);
    chk("lu_c1_bub", bub_a, 1);
    chk("lu_c1_cnt", lu_a, 0);
    tick();
    chk("lu_c1_cnt_after", lu_a, 1);
    set(mk(1,0,1,0,7, 3'b000,0, 3'b111,7,1, 2'b00,0, 0, 0,0,0,0,0,0));
    @(negedge clk);
    chk("lu_c2_s2", s2_a, 3);
    chk("lu_c2_fe", fe_a, 0);
    chk("lu_c2_sc", sc_a, 1);

    do_reset();
    set(mw_v);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mw%0d_all", i), all_a, 1);
      chk($sformatf("mw%0d_bub", i), bub_a, 0);
      tick();
    end
    mw_v.mr = 1'b1;
    set(mw_v);
    @(negedge clk);
    chk("mw_rel_all", all_a, 0);
    chk("mw_rel_fe", fe_a, 0);
    chk("mw_sc", sc_a, 3);
    tick();
    chk("mw_sc_hold", sc_a, 3);

    do_reset();
    set(lu_v);
    tick();
    chk("lu_cnt_1", lu_a, 1);
    tick();
    chk("lu_no_recount", lu_a, 1);
    tick();
    chk("lu_cnt_2", lu_a, 2);
    for (int i = 0; i < 40; i++) tick();
    chk("sat_lu", lu_a, 15);
    chk("sat_sc", sc_a, 15);
    chk("sat_sc0", sc_b, 15);
    chk("sat_lu0", lu_b, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstc_fe", fe_a, 1);
    chk("rstc_bub", bub_a, 1);
    tick();
    chk("rstc_sc", sc_a, 0);
    chk("rstc_lu", lu_a, 0);
    chk("rstc_sc0", sc_b, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_lu", lu_a, 1);

    set(mw_v);
    mw_v.mr = 1'b0;
    set(mw_v);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mw_sc", sc_a, 0);
    rst_n = 1'b1;
    set(lu_v);
    tick();
    chk("rst_mw_lu", lu_a, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
